// File: rtl/traffic_phase_scheduler.sv
// Purpose: main/side intersection phase scheduler with pedestrian walk phase and request arbitration.
// Latency: requests are latched one edge after they are sampled; lamps decode combinationally from the registered phase.
// Backpressure: none; requests are level/pulse inputs held in sticky latches until their phase is served.
//
// Ports:
//   clk, rst_n                        - clock, synchronous active-low reset
//   side_req, ped_req                 - side-road sensor (level), pedestrian button (level or pulse)
//   main_road_light, side_road_light  - 3'b001 green, 3'b011 yellow, 3'b101 red
//   ped_walk, ped_ack                 - walk lamp, one-cycle pulse on the first cycle of a walk phase
//   phase, second                     - current phase encoding, whole seconds elapsed in the phase
module traffic_phase_scheduler #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int MIN_GREEN     = 10,
  parameter int MAX_GREEN     = 30,
  parameter int YELLOW_T      = 3,
  parameter int ALLRED_T      = 2,
  parameter int WALK_T        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_road_light,
  output logic [2:0] side_road_light,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] phase,
  output logic [7:0] second
);

  localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);

  // Timed phases compare against T-1: the exit edge is the last tick of the final second.
  localparam logic [7:0] MIN_G    = 8'(MIN_GREEN);
  localparam logic [7:0] MAX_LAST = 8'(MAX_GREEN - 1);
  localparam logic [7:0] YEL_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] AR_LAST  = 8'(ALLRED_T - 1);
  localparam logic [7:0] WLK_LAST = 8'(WALK_T - 1);

  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b011;
  localparam logic [2:0] LAMP_RED = 3'b101;

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5,
    PW  = 3'd6
  } phase_t;

  phase_t          state, state_n;
  logic [PS_W-1:0] prescaler;
  logic            sec_tick;
  logic            side_pend, ped_pend;
  logic            rr, rr_n;
  logic            phase_chg;

  assign sec_tick  = (prescaler == PS_LAST);
  assign phase_chg = (state_n != state);
  assign phase     = state;

  // Next-phase selection and round-robin pointer update.
  always_comb begin
    state_n = state;
    rr_n    = rr;
    case (state)
      MG: begin
        if ((second >= MIN_G) && (side_pend || ped_pend)) state_n = MY;
      end
      MY: begin
        if (sec_tick && (second == YEL_LAST)) state_n = AR1;
      end
      AR1: begin
        if (sec_tick && (second == AR_LAST)) begin
          if (side_pend && ped_pend) begin
            // rr=0 serves the side road first; the pointer flips to the other requester.
            state_n = rr ? PW : SG;
            rr_n    = ~rr;
          end else if (side_pend) begin
            state_n = SG;
          end else if (ped_pend) begin
            state_n = PW;
          end else begin
            state_n = MG;
          end
        end
      end
      SG: begin
        // A waiting pedestrian ends side green as soon as the minimum is met, even with traffic present.
        if (((second >= MIN_G) && (!side_req || ped_pend)) ||
            (sec_tick && (second == MAX_LAST))) state_n = SY;
      end
      SY: begin
        if (sec_tick && (second == YEL_LAST)) state_n = AR2;
      end
      AR2: begin
        if (sec_tick && (second == AR_LAST)) state_n = MG;
      end
      PW: begin
        if (sec_tick && (second == WLK_LAST)) state_n = AR2;
      end
      default: state_n = MG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= MG;
      prescaler <= '0;
      second    <= '0;
      side_pend <= 1'b0;
      ped_pend  <= 1'b0;
      rr        <= 1'b0;
      ped_ack   <= 1'b0;
    end else begin
      state <= state_n;
      rr    <= rr_n;

      // Every phase starts on a clean second boundary.
      if (phase_chg) begin
        prescaler <= '0;
        second    <= '0;
      end else begin
        prescaler <= sec_tick ? '0 : prescaler + PS_W'(1);
        if (sec_tick && (second != 8'hFF)) second <= second + 8'd1;
      end

      // Clear on entry takes priority over a same-cycle set.
      if ((state_n == SG) && (state != SG))  side_pend <= 1'b0;
      else if (side_req && (state != SG))    side_pend <= 1'b1;

      if ((state_n == PW) && (state != PW))  ped_pend <= 1'b0;
      else if (ped_req && (state != PW))     ped_pend <= 1'b1;

      ped_ack <= (state_n == PW) && (state != PW);
    end
  end

  // Lamp decode; anything not explicitly green or yellow stays red.
  always_comb begin
    main_road_light = LAMP_RED;
    side_road_light = LAMP_RED;
    ped_walk        = 1'b0;
    case (state)
      MG:      main_road_light = LAMP_GRN;
      MY:      main_road_light = LAMP_YEL;
      SG:      side_road_light = LAMP_GRN;
      SY:      side_road_light = LAMP_YEL;
      PW:      ped_walk        = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  localparam logic [2:0] P_MG = 3'd0, P_MY = 3'd1, P_AR1 = 3'd2, P_SG = 3'd3,
                         P_SY = 3'd4, P_AR2 = 3'd5, P_PW = 3'd6;
  localparam logic [2:0] GRN = 3'b001, YEL = 3'b011, RED = 3'b101;

  logic       clk;
  logic       rst_n;
  logic       side_req;
  logic       ped_req;
  logic [2:0] main_road_light;
  logic [2:0] side_road_light;
  logic       ped_walk;
  logic       ped_ack;
  logic [2:0] phase;
  logic [7:0] second;

  int total = 0;
  int bad   = 0;

  traffic_phase_scheduler #(
    .TICKS_PER_SEC(4),
    .MIN_GREEN    (3),
    .MAX_GREEN    (6),
    .YELLOW_T     (2),
    .ALLRED_T     (1),
    .WALK_T       (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .side_req       (side_req),
    .ped_req        (ped_req),
    .main_road_light(main_road_light),
    .side_road_light(side_road_light),
    .ped_walk       (ped_walk),
    .ped_ack        (ped_ack),
    .phase          (phase),
    .second         (second)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  // Counts edges until the phase reaches p (bounded) and checks the dwell.
  task automatic wait_for(input string tag, input logic [2:0] p, input int exp_n);
    int n;
    n = 0;
    while ((phase !== p) && (n < exp_n + 20)) begin
      step(1);
      n++;
    end
    chk({tag, "_phase"}, 32'(phase), 32'(p));
    chk({tag, "_dwell"}, 32'(n), 32'(exp_n));
  endtask

  // Main and side must never both be non-red.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      assert (!((main_road_light != RED) && (side_road_light != RED)))
        else begin
          bad++;
          $error("FAIL lamp_conflict main=%b side=%b required one red", main_road_light, side_road_light);
        end
    end
  end

  initial begin
    rst_n    = 1'b0;
    side_req = 1'b0;
    ped_req  = 1'b0;
    step(3);
    chk("rst_phase", 32'(phase), 32'(P_MG));
    chk("rst_second", 32'(second), 0);
    chk("rst_main", 32'(main_road_light), 32'(GRN));
    chk("rst_side", 32'(side_road_light), 32'(RED));
    chk("rst_walk", 32'(ped_walk), 0);
    chk("rst_ack", 32'(ped_ack), 0);

    // Idle: MG holds, seconds count and saturate.
    rst_n = 1'b1;
    step(200);
    chk("idle_phase", 32'(phase), 32'(P_MG));
    chk("idle_second", 32'(second), 50);
    chk("idle_main", 32'(main_road_light), 32'(GRN));
    chk("idle_side", 32'(side_road_light), 32'(RED));
    chk("idle_walk", 32'(ped_walk), 0);
    step(819);
    chk("sec_254", 32'(second), 254);
    step(1);
    chk("sec_255", 32'(second), 255);
    step(80);
    chk("sec_sat", 32'(second), 255);
    chk("sat_phase", 32'(phase), 32'(P_MG));

    // Side request held high: SG forced out at MAX_GREEN.
    do_reset();
    step(2);
    side_req = 1'b1;
    wait_for("t2_my", P_MY, 11);
    chk("t2_my_main", 32'(main_road_light), 32'(YEL));
    chk("t2_my_side", 32'(side_road_light), 32'(RED));
    chk("t2_my_sec", 32'(second), 0);
    wait_for("t2_ar1", P_AR1, 8);
    chk("t2_ar1_main", 32'(main_road_light), 32'(RED));
    wait_for("t2_sg", P_SG, 4);
    chk("t2_sg_main", 32'(main_road_light), 32'(RED));
    chk("t2_sg_side", 32'(side_road_light), 32'(GRN));
    wait_for("t2_sy_max", P_SY, 24);
    chk("t2_sy_side", 32'(side_road_light), 32'(YEL));
    wait_for("t2_ar2", P_AR2, 8);
    wait_for("t2_mg", P_MG, 4);
    chk("t2_mg_main", 32'(main_road_light), 32'(GRN));
    // Request latched during SY/AR2 is served again; with side_req low SG ends at MIN_GREEN.
    side_req = 1'b0;
    wait_for("t2b_my", P_MY, 13);
    wait_for("t2b_ar1", P_AR1, 8);
    wait_for("t2b_sg", P_SG, 4);
    wait_for("t2b_sy_min", P_SY, 13);
    wait_for("t2b_ar2", P_AR2, 8);
    wait_for("t2b_mg", P_MG, 4);
    step(20);
    chk("t2b_hold", 32'(phase), 32'(P_MG));

    // Single-cycle pedestrian press after MIN_GREEN; re-press during PW ignored.
    do_reset();
    step(20);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    wait_for("t3_my", P_MY, 1);
    wait_for("t3_ar1", P_AR1, 8);
    wait_for("t3_pw", P_PW, 4);
    chk("t3_ack_hi", 32'(ped_ack), 1);
    chk("t3_walk", 32'(ped_walk), 1);
    chk("t3_pw_main", 32'(main_road_light), 32'(RED));
    chk("t3_pw_side", 32'(side_road_light), 32'(RED));
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    chk("t3_ack_lo", 32'(ped_ack), 0);
    chk("t3_walk2", 32'(ped_walk), 1);
    wait_for("t3_ar2", P_AR2, 15);
    chk("t3_walk_off", 32'(ped_walk), 0);
    wait_for("t3_mg", P_MG, 4);
    step(20);
    chk("t3_no_repw", 32'(phase), 32'(P_MG));

    // Both requests before MIN_GREEN: side first, ped cuts SG at MIN_GREEN, then PW.
    do_reset();
    step(1);
    side_req = 1'b1;
    ped_req  = 1'b1;
    step(1);
    ped_req  = 1'b0;
    wait_for("t4_my", P_MY, 11);
    wait_for("t4_ar1", P_AR1, 8);
    wait_for("t4_sg", P_SG, 4);
    wait_for("t4_sy_ped", P_SY, 13);
    side_req = 1'b0;
    wait_for("t4_ar2", P_AR2, 8);
    wait_for("t4_mg", P_MG, 4);
    wait_for("t4_my2", P_MY, 13);
    wait_for("t4_ar1b", P_AR1, 8);
    wait_for("t4_pw", P_PW, 4);
    chk("t4_ack", 32'(ped_ack), 1);
    wait_for("t4_ar2b", P_AR2, 16);
    // Press during AR2 is latched and served after the next MIN_GREEN.
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    wait_for("t6_mg", P_MG, 3);
    wait_for("t6_my", P_MY, 13);
    wait_for("t6_ar1", P_AR1, 8);
    wait_for("t6_pw", P_PW, 4);
    chk("t6_ack", 32'(ped_ack), 1);
    wait_for("t6_ar2", P_AR2, 16);
    wait_for("t6_mg2", P_MG, 4);
    step(20);
    chk("t6_hold", 32'(phase), 32'(P_MG));

    // Round-robin pointer now favours the pedestrian.
    side_req = 1'b1;
    ped_req  = 1'b1;
    step(1);
    ped_req  = 1'b0;
    wait_for("rr_my", P_MY, 1);
    wait_for("rr_ar1", P_AR1, 8);
    wait_for("rr_pw_first", P_PW, 4);
    wait_for("rr_ar2", P_AR2, 16);
    wait_for("rr_mg", P_MG, 4);
    wait_for("rr_my2", P_MY, 13);
    wait_for("rr_ar1b", P_AR1, 8);
    wait_for("rr_sg_second", P_SG, 4);
    side_req = 1'b0;

    // Reset mid-SG returns straight to MG with latches cleared.
    do_reset();
    side_req = 1'b1;
    step(1);
    side_req = 1'b0;
    wait_for("t5_sg", P_SG, 24);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    step(4);
    chk("t5_in_sg", 32'(phase), 32'(P_SG));
    chk("t5_sg_sec", 32'(second), 1);
    rst_n = 1'b0;
    step(1);
    chk("t5_phase", 32'(phase), 32'(P_MG));
    chk("t5_second", 32'(second), 0);
    chk("t5_main", 32'(main_road_light), 32'(GRN));
    chk("t5_side", 32'(side_road_light), 32'(RED));
    chk("t5_walk", 32'(ped_walk), 0);
    rst_n = 1'b1;
    step(20);
    chk("t5_hold", 32'(phase), 32'(P_MG));
    chk("t5_hold_sec", 32'(second), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
